// File: rtl/odo_round_key_sched.sv
// Sequences the 10-entry Odo round-key ROM over NUM_ROUNDS rounds, streaming keys with valid/ready.
// Optional stall counter output enabled by ODO_ROUND_KEY_SCHED_STALL_CNT_EN.
module odo_round_key_sched #(
    parameter int unsigned NUM_ROUNDS   = 84,
    parameter int unsigned ROUND_W      = 7,
    parameter int unsigned FIRST_PERIOD = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic [3:0]         rom_period,
    input  logic [9:0]         rom_key,
    output logic [9:0]         key_out,
    output logic [ROUND_W-1:0] round_out,
    output logic               key_valid,
    input  logic               key_ready,
    output logic               last,
    output logic               done
`ifdef ODO_ROUND_KEY_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam logic [3:0]         FIRST_P    = 4'(FIRST_PERIOD);
    localparam logic [3:0]         LAST_P     = 4'd9;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         period_q, period_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [3:0]         next_period;
    logic               handshake;
    logic               is_last;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= FIRST_P;
            round_q  <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            round_q  <= round_d;
        end
    end

    assign next_period = (period_q == LAST_P) ? 4'd0 : period_q + 4'd1;
    assign handshake   = (state_q == STREAM) && key_ready;
    assign is_last     = (round_q == LAST_ROUND);

    // Next state, counter update and ROM addressing; abort outranks a same-cycle handshake
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        round_d    = round_q;
        rom_period = period_q;
        case (state_q)
            IDLE: begin
                rom_period = FIRST_P;
                if (start && !abort) state_d = PRIME;
            end
            PRIME: begin
                rom_period = FIRST_P;
                state_d    = abort ? IDLE : STREAM;
            end
            STREAM: begin
                if (handshake && !is_last) rom_period = next_period;
                if (abort) begin
                    state_d  = IDLE;
                    period_d = FIRST_P;
                    round_d  = '0;
                end else if (handshake) begin
                    if (is_last) begin
                        state_d  = DONE;
                        period_d = FIRST_P;
                        round_d  = '0;
                    end else begin
                        period_d = next_period;
                        round_d  = round_q + ROUND_W'(1);
                    end
                end
            end
            DONE: begin
                rom_period = FIRST_P;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == PRIME) || (state_q == STREAM);
    assign key_valid = (state_q == STREAM);
    assign key_out   = key_valid ? rom_key : 10'd0;
    assign round_out = round_q;
    assign last      = key_valid && is_last;
    assign done      = (state_q == DONE);

`ifdef ODO_ROUND_KEY_SCHED_STALL_CNT_EN
    // Saturating count of backpressured STREAM cycles, cleared when a new sequence starts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (state_q == IDLE && state_d == PRIME) begin
            stall_cnt <= 16'd0;
        end else if (state_q == STREAM && !key_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_odo_round_key_sched.sv
// Directed bench for odo_round_key_sched: two instances (FIRST_PERIOD 0 and 7) share stimulus,
// each driving its own registered ROM model. Define ODO_ROUND_KEY_SCHED_STALL_CNT_EN to check stall_cnt.
module tb_odo_round_key_sched;

    localparam int unsigned ROUND_W = 7;
    localparam int unsigned NROUNDS = 84;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic key_ready = 1'b0;

    logic               busy0, busy1, key_valid0, key_valid1, last0, last1, done0, done1;
    logic [3:0]         rom_period0, rom_period1;
    logic [9:0]         rom_key0, rom_key1, key_out0, key_out1;
    logic [ROUND_W-1:0] round_out0, round_out1;
`ifdef ODO_ROUND_KEY_SCHED_STALL_CNT_EN
    logic [15:0]        stall_cnt0, stall_cnt1;
`endif

    logic [9:0] key_tbl [10] = '{10'h10e, 10'h0c1, 10'h120, 10'h21d, 10'h311,
                                 10'h240, 10'h366, 10'h3c6, 10'h2e2, 10'h144};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Registered ROM models
    always_ff @(posedge clk) begin
        rom_key0 <= (rom_period0 < 4'd10) ? key_tbl[rom_period0] : 10'd0;
        rom_key1 <= (rom_period1 < 4'd10) ? key_tbl[rom_period1] : 10'd0;
    end

    odo_round_key_sched #(.NUM_ROUNDS(NROUNDS), .ROUND_W(ROUND_W), .FIRST_PERIOD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy0),
        .rom_period(rom_period0), .rom_key(rom_key0), .key_out(key_out0),
        .round_out(round_out0), .key_valid(key_valid0), .key_ready(key_ready),
        .last(last0), .done(done0)
`ifdef ODO_ROUND_KEY_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt0)
`endif
    );

    odo_round_key_sched #(.NUM_ROUNDS(NROUNDS), .ROUND_W(ROUND_W), .FIRST_PERIOD(7)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy1),
        .rom_period(rom_period1), .rom_key(rom_key1), .key_out(key_out1),
        .round_out(round_out1), .key_valid(key_valid1), .key_ready(key_ready),
        .last(last1), .done(done1)
`ifdef ODO_ROUND_KEY_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},      32'(busy0),       32'd0);
        check({tag, " key_valid"}, 32'(key_valid0),  32'd0);
        check({tag, " last"},      32'(last0),       32'd0);
        check({tag, " done"},      32'(done0),       32'd0);
        check({tag, " round"},     32'(round_out0),  32'd0);
        check({tag, " period0"},   32'(rom_period0), 32'd0);
        check({tag, " period1"},   32'(rom_period1), 32'd7);
    endtask

    // One sequence: optional stall run, abort round or reset round (-1 disables each)
    task automatic run_seq(input int stall_at, input int stall_len, input int abort_at, input int rst_at);
        int r;
        int stalled;
        logic rdy;
        r = 0;
        stalled = 0;
        start = 1'b1;
        key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("prime busy", 32'(busy0), 32'd1);
        check("prime key_valid", 32'(key_valid0), 32'd0);
`ifdef ODO_ROUND_KEY_SCHED_STALL_CNT_EN
        check("prime stall_cnt clear", 32'(stall_cnt0), 32'd0);
`endif
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("key_valid", 32'(key_valid0), 32'd1);
            check("round_out", 32'(round_out0), 32'(r));
            check("key_out", 32'(key_out0), 32'(key_tbl[r % 10]));
            check("key_out fp7", 32'(key_out1), 32'(key_tbl[(r + 7) % 10]));
            check("last", 32'(last0), 32'(r == NROUNDS - 1));
            check("done low", 32'(done0), 32'd0);
            if (r == abort_at) begin
                abort = 1'b1;
                key_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_idle("abort");
                @(negedge clk);
                check("abort no done", 32'(done0), 32'd0);
                return;
            end
            if (r == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check_idle("mid reset");
                return;
            end
            rdy = !(r == stall_at && stalled < stall_len);
            if (!rdy) stalled++;
            start = (r == 50);
            key_ready = rdy;
            @(negedge clk);
            start = 1'b0;
            if (rdy) r++;
            if (r == NROUNDS) break;
        end
        check("round count reached", 32'(r), 32'(NROUNDS));
        key_ready = 1'b1;
        check("done pulse", 32'(done0), 32'd1);
        check("done key_valid", 32'(key_valid0), 32'd0);
        check("done fp7", 32'(done1), 32'd1);
        @(negedge clk);
        check("done one cycle", 32'(done0), 32'd0);
        check("idle after done", 32'(busy0), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_idle("reset");

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort stays idle", 32'(busy0), 32'd0);
        @(negedge clk);
        check("start+abort no valid", 32'(key_valid0), 32'd0);

        run_seq(-1, 0, -1, -1);
        run_seq(9, 3, -1, -1);
`ifdef ODO_ROUND_KEY_SCHED_STALL_CNT_EN
        check("stall_cnt 3", 32'(stall_cnt0), 32'd3);
`endif
        run_seq(-1, 0, 40, -1);
        run_seq(-1, 0, -1, 20);
        run_seq(5, 25, -1, -1);
`ifdef ODO_ROUND_KEY_SCHED_STALL_CNT_EN
        check("stall_cnt 25", 32'(stall_cnt0), 32'd25);
        check("stall_cnt 25 fp7", 32'(stall_cnt1), 32'd25);
`endif
        run_seq(-1, 0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/odo_round_key_sched.md
Name: odo_round_key_sched

Overview:
- Sequences the registered 10-entry Odo round-key ROM (period 0..9 in, 10-bit key out, 1-cycle latency) across all rounds of one hash evaluation.
- Streams one key per cycle to the round datapath using a valid/ready handshake, and holds the current key stable under backpressure.
- Sits between the miner control FSM (start/abort/done) and the round pipeline; it is the only block that drives the ROM's period input.

Parameters:
- NUM_ROUNDS, 84, rounds per evaluation (1..2^ROUND_W).
- ROUND_W, 7, width of round index.
- FIRST_PERIOD, 0, ROM period used for round 0 (0..9).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin sequence; sampled only in IDLE.
- abort  in  1  cancel sequence; returns to IDLE.
- busy  out  1  high in PRIME or STREAM.
- rom_period  out  4  to ROM period input; combinational next-period.
- rom_key  in  10  ROM key output (registered in ROM).
- key_out  out  10  round key, equals rom_key while key_valid.
- round_out  out  ROUND_W  index of the round whose key is presented.
- key_valid  out  1  key_out/round_out valid.
- key_ready  in  1  downstream accepts the key this cycle.
- last  out  1  key_valid and round_out==NUM_ROUNDS-1.
- done  out  1  one-cycle pulse after the last key is accepted.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, period_q=FIRST_PERIOD, round_q=0; busy=0, key_valid=0, last=0, done=0. rom_period=FIRST_PERIOD.
- States:
  - IDLE --start&!abort--> PRIME.
  - PRIME --> STREAM; abort sends it to IDLE instead.
  - STREAM --handshake on last--> DONE; abort --> IDLE.
  - DONE --> IDLE unconditionally.
- handshake = key_valid & key_ready.
- rom_period:
  - = next_period when in STREAM with handshake and not last.
  - = FIRST_PERIOD in IDLE/PRIME/DONE.
  - = period_q otherwise.
  - next_period = (period_q==9) ? 0 : period_q+1.
  - The ROM therefore holds the correct key the cycle after each advance, giving no bubbles.
- Latency: start seen at edge N → PRIME; ROM captures FIRST_PERIOD at edge N+1; key_valid high from the cycle after edge N+1 (2 cycles after the start cycle).
- STREAM: key_valid=1, key_out=rom_key.
  - On handshake, not last: round_q+1, period_q=next_period, key_valid stays 1.
  - On handshake, last: key_valid drops next cycle; done=1 for exactly one cycle (DONE state); period_q and round_q reload FIRST_PERIOD/0.
- Backpressure: key_ready=0 → period_q, round_q, rom_period hold, so key_out stays stable; no key is skipped or duplicated.
- Period wrap 9→0 is independent of the round count; round_q never wraps within a sequence.
- NUM_ROUNDS=1: first key has last=1; a single handshake completes the sequence.
- abort:
  - Highest priority in every state; acts at the next edge, overriding a same-cycle handshake.
  - Goes to IDLE with key_valid=0 and no done pulse; counters reload.
- start outside IDLE is ignored. start and abort together in IDLE → stay IDLE.
- rst_n low mid-sequence: identical to the reset values above at the next edge.
- rom_key is ignored outside STREAM.

Optional Feature:
- Macro ODO_ROUND_KEY_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[15:0], counting STREAM cycles with key_valid&!key_ready.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on each IDLE→PRIME transition; holds its value after done or abort.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then start pulse, key_ready=1 → key_valid 2 cycles later; keys stream 10e,0c1,120,21d,311,240,366,3c6,2e2,144,10e… with round_out 0..83; round 83 key=21d with last=1; done pulse the next cycle; 84 consecutive valid cycles.
- key_ready low for 3 cycles at round 9 (key 144) → key_out=144 and round_out=9 held for 3 cycles; next accepted key is 10e at round 10; no gaps or duplicates.
- abort asserted during a handshake at round 40 → next cycle IDLE, key_valid=0, no done pulse; a following start restarts at round 0 with key 10e.
- start with abort in the same IDLE cycle → stays IDLE; start pulses during STREAM → ignored, sequence length still 84.
- rst_n low at round 20, then released → all outputs at reset values; a new start gives round 0 key 10e. With FIRST_PERIOD=7, round 0 key=3c6 and round 3 key=10e.
- With ODO_ROUND_KEY_SCHED_STALL_CNT_EN: random key_ready with 25 low cycles inside STREAM → stall_cnt=25 after done; it clears to 0 on the next start.
